// File: rtl/swd_host_engine_if.sv
// Command/response bundle between an SWD host engine and its client.
// The cmd_lrst field exists only when SWD_LINE_RESET_EN is defined.
interface swd_host_engine_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_apndp;
    logic        cmd_rnw;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
`ifdef SWD_LINE_RESET_EN
    logic        cmd_lrst;
`endif
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;

`ifdef SWD_LINE_RESET_EN
    modport master (output cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, cmd_lrst,
                    input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr);
    modport slave  (input  cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata, cmd_lrst,
                    output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr);
`else
    modport master (output cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata,
                    input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr);
    modport slave  (input  cmd_valid, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata,
                    output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr);
`endif
endinterface

// File: rtl/swd_host_engine.sv
// SWD host engine: runs one SWD read/write transaction per accepted command.
// Optional SWD_LINE_RESET_EN adds cmd_lrst, issuing a 56-bit line reset instead.
module swd_host_engine #(
    parameter int CLK_DIV   = 4,
    parameter int IDLE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    swd_host_engine_if.slave bus,
    output logic             swclk,
    output logic             swd_o,
    output logic             swd_oe,
    input  logic             swd_i
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_REQ   = 4'd1;
    localparam logic [3:0] S_TRN1  = 4'd2;
    localparam logic [3:0] S_ACK   = 4'd3;
    localparam logic [3:0] S_RDATA = 4'd4;
    localparam logic [3:0] S_TRN2  = 4'd5;
    localparam logic [3:0] S_WDATA = 4'd6;
    localparam logic [3:0] S_TAIL  = 4'd7;
`ifdef SWD_LINE_RESET_EN
    localparam logic [3:0] S_LRST  = 4'd8;
`endif
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [8:0] DIV_RISE  = 9'(CLK_DIV - 1);
    localparam logic [8:0] DIV_END   = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] TAIL_LAST = 6'(IDLE_BITS - 1);

    logic [3:0]  state, state_n;
    logic [8:0]  div;
    logic [5:0]  bit_cnt, bit_cnt_n;
    logic        cmd_ready, rsp_valid, rsp_perr;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        apndp_q, rnw_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  ack_sr;
    logic [31:0] rdata_sr;
    logic        rpar_q;
    logic [7:0]  req_word;
    logic        ack_ok, rd_ok, drv_oe, drv_o;
    logic [3:0]  start_state;

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_ack   = rsp_ack;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_perr  = rsp_perr;

    // Wire order is LSB-first: start, APnDP, RnW, A2, A3, parity, stop, park.
    assign req_word = {1'b1, 1'b0, apndp_q ^ rnw_q ^ addr_q[0] ^ addr_q[1],
                       addr_q[1], addr_q[0], rnw_q, apndp_q, 1'b1};
    assign ack_ok   = (ack_sr == 3'b001);
    assign rd_ok    = ack_ok && rnw_q;

`ifdef SWD_LINE_RESET_EN
    assign start_state = bus.cmd_lrst ? S_LRST : S_REQ;
`else
    assign start_state = S_REQ;
`endif

    // Next state/bit index, evaluated at the end of the current bit.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + 6'd1;
        case (state)
            S_REQ:   if (bit_cnt == 6'd7)  begin state_n = S_TRN1; bit_cnt_n = '0; end
            S_TRN1:  begin state_n = S_ACK; bit_cnt_n = '0; end
            S_ACK:   if (bit_cnt == 6'd2)  begin state_n = rd_ok ? S_RDATA : S_TRN2; bit_cnt_n = '0; end
            S_RDATA: if (bit_cnt == 6'd32) begin state_n = S_TRN2; bit_cnt_n = '0; end
            S_TRN2:  begin state_n = (ack_ok && !rnw_q) ? S_WDATA : S_TAIL; bit_cnt_n = '0; end
            S_WDATA: if (bit_cnt == 6'd32) begin state_n = S_TAIL; bit_cnt_n = '0; end
`ifdef SWD_LINE_RESET_EN
            S_LRST:  if (bit_cnt == 6'd55) begin state_n = S_TAIL; bit_cnt_n = '0; end
`endif
            S_TAIL:  if (bit_cnt == TAIL_LAST) begin state_n = S_DONE; bit_cnt_n = '0; end
            default: ;
        endcase
    end

    // Pad drive for the bit that is about to start.
    always_comb begin
        drv_oe = 1'b1;
        drv_o  = 1'b1;
        case (state_n)
            S_REQ:                         drv_o  = req_word[bit_cnt_n[2:0]];
            S_TRN1, S_ACK, S_RDATA, S_TRN2: drv_oe = 1'b0;
            S_WDATA: drv_o = bit_cnt_n[5] ? ^wdata_q : wdata_q[bit_cnt_n[4:0]];
            S_TAIL:                        drv_o  = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            swclk     <= 1'b1;
            swd_oe    <= 1'b1;
            swd_o     <= 1'b1;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ack   <= '0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
            apndp_q   <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_sr    <= '0;
            rdata_sr  <= '0;
            rpar_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_ready && bus.cmd_valid) begin
                        apndp_q   <= bus.cmd_apndp;
                        rnw_q     <= bus.cmd_rnw;
                        addr_q    <= bus.cmd_addr;
                        wdata_q   <= bus.cmd_wdata;
                        ack_sr    <= '0;
                        rdata_sr  <= '0;
                        rpar_q    <= 1'b0;
                        state     <= start_state;
                        bit_cnt   <= '0;
                        div       <= '0;
                        cmd_ready <= 1'b0;
                        // First bit of both REQ and LRST is a 1.
                        swclk     <= 1'b0;
                        swd_oe    <= 1'b1;
                        swd_o     <= 1'b1;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    if (div == DIV_END) begin
                        div     <= '0;
                        state   <= state_n;
                        bit_cnt <= bit_cnt_n;
                        if (state_n == S_DONE) begin
                            rsp_valid <= 1'b1;
                            rsp_ack   <= ack_sr;
                            rsp_rdata <= rd_ok ? rdata_sr : '0;
                            rsp_perr  <= rd_ok & (rpar_q ^ (^rdata_sr));
                            swd_oe    <= 1'b1;
                            swd_o     <= 1'b1;
                        end else begin
                            swclk  <= 1'b0;
                            swd_oe <= drv_oe;
                            swd_o  <= drv_o;
                        end
                    end else begin
                        div <= div + 9'd1;
                        if (div == DIV_RISE) begin
                            swclk <= 1'b1;
                            if (state == S_ACK)
                                ack_sr <= {swd_i, ack_sr[2:1]};
                            if (state == S_RDATA) begin
                                if (bit_cnt[5]) rpar_q   <= swd_i;
                                else            rdata_sr <= {swd_i, rdata_sr[31:1]};
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_swd_host_engine.sv
// Scoreboard bench for swd_host_engine: a wire-level target model feeds swd_i,
// expected responses and host drive patterns are queued at issue time.
module tb_swd_host_engine;
    localparam int D  = 3;
    localparam int IB = 2;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
        int          lat;
        int          nbits;
        logic [63:0] woe;
        logic [63:0] wo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic swclk, swd_o, swd_oe;
    logic swd_i = 1'b1;

    swd_host_engine_if bus();

    swd_host_engine #(.CLK_DIV(D), .IDLE_BITS(IB)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus.slave),
        .swclk (swclk),
        .swd_o (swd_o),
        .swd_oe(swd_oe),
        .swd_i (swd_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    int          passed = 0, total = 0, rsp_cnt = 0;
    int          bit_idx = -1, acc_cyc = 0;
    logic [63:0] tgt = '0, cap_oe = '0, cap_o = '0;
    logic [2:0]  last_ack = '0;
    logic [31:0] last_rdata = '0;
    logic        last_perr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    // Reference: lay out the transaction bit by bit from the protocol rules.
    task automatic model(input logic apndp, input logic rnw, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [2:0] ack, input logic [31:0] rd,
                         input logic rp, input logic lrst, output exp_t e, output logic [63:0] t);
        logic [7:0] req;
        int n;
        e.woe = '0; e.wo = '0; e.ack = '0; e.rdata = '0; e.perr = 1'b0;
        t = {$urandom, $urandom};
        n = 0;
        if (lrst) begin
            for (int i = 0; i < 56; i++) begin e.woe[n] = 1'b1; e.wo[n] = 1'b1; n++; end
        end else begin
            req = {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
            for (int i = 0; i < 8; i++) begin e.woe[n] = 1'b1; e.wo[n] = req[i]; n++; end
            n++;
            for (int i = 0; i < 3; i++) begin t[n] = ack[i]; n++; end
            e.ack = ack;
            if (ack == 3'b001 && rnw) begin
                for (int i = 0; i < 32; i++) begin t[n] = rd[i]; n++; end
                t[n] = rp; n++;
                n++;
                e.rdata = rd;
                e.perr  = rp ^ (^rd);
            end else if (ack == 3'b001) begin
                n++;
                for (int i = 0; i < 32; i++) begin e.woe[n] = 1'b1; e.wo[n] = wd[i]; n++; end
                e.woe[n] = 1'b1; e.wo[n] = ^wd; n++;
            end else begin
                n++;
            end
        end
        for (int i = 0; i < IB; i++) begin e.woe[n] = 1'b1; e.wo[n] = 1'b0; n++; end
        e.nbits = n;
        e.lat   = n * 2 * D;
    endtask

    // Target: presents its bit on each falling swclk.
    initial begin
        forever begin
            @(negedge swclk);
            bit_idx = bit_idx + 1;
            if (bit_idx >= 0 && bit_idx < 64) swd_i = tgt[bit_idx];
        end
    end

    // Host-drive capture at each rising swclk.
    initial begin
        forever begin
            @(posedge swclk);
            #1;
            if (bit_idx >= 0 && bit_idx < 64) begin
                cap_oe[bit_idx] = swd_oe;
                cap_o[bit_idx]  = swd_o;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        logic [63:0] m;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    m = (64'd1 << e.nbits) - 64'd1;
                    chk("rsp_ack",   64'(bus.rsp_ack),   64'(e.ack));
                    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    chk("rsp_perr",  64'(bus.rsp_perr),  64'(e.perr));
                    chk("latency",   64'(cyc - acc_cyc), 64'(e.lat));
                    chk("bit_count", 64'(bit_idx + 1),   64'(e.nbits));
                    chk("wire_oe",   cap_oe & m,         e.woe & m);
                    chk("wire_o",    cap_o & e.woe & m,  e.wo & e.woe & m);
                    last_ack = e.ack; last_rdata = e.rdata; last_perr = e.perr;
                end
            end
        end
    end

    task automatic send(input logic apndp, input logic rnw, input logic [1:0] addr,
                        input logic [31:0] wd, input logic [2:0] ack, input logic [31:0] rd,
                        input logic rp, input logic lrst, input bit expect_rsp);
        exp_t e;
        logic [63:0] t;
        int to;
        model(apndp, rnw, addr, wd, ack, rd, rp, lrst, e, t);
        @(negedge clk);
        to = 0;
        while (bus.cmd_ready !== 1'b1 && to < 1000) begin @(negedge clk); to++; end
        if (bus.cmd_ready !== 1'b1) begin
            total++;
            $display("FAIL cmd_ready_timeout: got %b want 1", bus.cmd_ready);
            return;
        end
        chk("hold_ack",   64'(bus.rsp_ack),   64'(last_ack));
        chk("hold_rdata", 64'(bus.rsp_rdata), 64'(last_rdata));
        chk("hold_perr",  64'(bus.rsp_perr),  64'(last_perr));
        tgt = t; bit_idx = -1; cap_oe = 'x; cap_o = 'x;
        bus.cmd_valid = 1'b1;
        bus.cmd_apndp = apndp;
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
`ifdef SWD_LINE_RESET_EN
        bus.cmd_lrst  = lrst;
`endif
        acc_cyc = cyc + 1;
        if (expect_rsp) sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n0, to;
        n0 = rsp_cnt;
        to = 0;
        while (rsp_cnt == n0 && to < 2000) begin @(negedge clk); to++; end
        if (rsp_cnt == n0) begin
            total++;
            $display("FAIL rsp_timeout: got no rsp_valid want one");
        end
    endtask

    initial begin
        logic [2:0] oth [0:4];
        logic [2:0] ack;
        logic [31:0] rd;
        int r, to;
        oth = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        bus.cmd_valid = 1'b0; bus.cmd_apndp = 1'b0; bus.cmd_rnw = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
`ifdef SWD_LINE_RESET_EN
        bus.cmd_lrst = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_swclk",     64'(swclk),         64'd1);
        chk("rst_swd_oe",    64'(swd_oe),        64'd1);
        chk("rst_swd_o",     64'(swd_o),         64'd1);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_ack",   64'(bus.rsp_ack),   64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_perr",  64'(bus.rsp_perr),  64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

        // DP read of IDCODE-like value.
        send(1'b0, 1'b1, 2'd0, 32'h0, 3'b001, 32'h2BA01477, 1'b0, 1'b0, 1'b1);
        wait_rsp();
        chk("req_byte", 64'(cap_o[7:0]), 64'h A5);

        // Reset during RDATA bit 10 (wire bit 22).
        send(1'b0, 1'b1, 2'd2, 32'h0, 3'b001, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        to = 0;
        while (bit_idx != 22 && to < 2000) begin @(negedge clk); to++; end
        chk("reach_rdata_bit10", 64'(bit_idx), 64'd22);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_swclk",     64'(swclk),         64'd1);
        chk("abort_swd_oe",    64'(swd_oe),        64'd1);
        chk("abort_swd_o",     64'(swd_o),         64'd1);
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("abort_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("abort_rsp_ack",   64'(bus.rsp_ack),   64'd0);
        last_ack = '0; last_rdata = '0; last_perr = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_abort", 64'(bus.cmd_ready), 64'd1);
        repeat (400) @(negedge clk);

        // AP write of 1, then WAIT, then parity error read.
        send(1'b1, 1'b0, 2'd1, 32'h00000001, 3'b001, 32'h0, 1'b0, 1'b0, 1'b1);
        wait_rsp();
        send(1'b0, 1'b1, 2'd1, 32'h0, 3'b010, 32'h12345678, 1'b1, 1'b0, 1'b1);
        wait_rsp();
        send(1'b1, 1'b1, 2'd3, 32'h0, 3'b001, 32'h00000003, 1'b1, 1'b0, 1'b1);
        wait_rsp();
`ifdef SWD_LINE_RESET_EN
        send(1'b0, 1'b0, 2'd0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b1, 1'b1);
        wait_rsp();
`endif

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 5);
            if (r <= 2)      ack = 3'b001;
            else if (r == 3) ack = 3'b010;
            else if (r == 4) ack = 3'b100;
            else             ack = oth[$urandom_range(0, 4)];
            rd = $urandom;
`ifdef SWD_LINE_RESET_EN
            send(1'($urandom), 1'($urandom), 2'($urandom), $urandom, ack, rd, 1'($urandom),
                 ($urandom_range(0, 7) == 0), 1'b1);
`else
            send(1'($urandom), 1'($urandom), 2'($urandom), $urandom, ack, rd, 1'($urandom),
                 1'b0, 1'b1);
`endif
            wait_rsp();
        end

        repeat (20) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
